mem_bridge16: RTL and testbench
===============================

Name: mem_bridge16

Overview:
- Responder end of the CPU byte bus (address/in/out/we/locked).
- Serves the core's 20-bit byte accesses from a 16-bit word memory behind a req/ack handshake.
- Holds the core's `locked` low (wait) while a backend access is in progress.
- Keeps a one-word read line buffer so that the second byte of a word, or a repeated fetch, completes without waiting.

Parameters:
- ROM_BASE, 20'hF0000, first byte address of the write-protected region (used only with the optional feature).
- ADDR_W, 20, CPU byte-address width; the backend word address is ADDR_W-1 bits.

Ports:
- clock  in  1  system clock, single domain.
- reset  in  1  synchronous, active-high reset.
- address  in  20  CPU byte address.
- out  in  8  CPU write data.
- we  in  1  CPU write strobe; one byte is committed per cycle in which we=1 and locked=1.
- in  out  8  read data to the CPU; valid in any cycle where locked=1 and we=0.
- locked  out  1  1 = the CPU may advance this cycle; 0 = the CPU holds all state.
- mem_addr  out  19  backend word address, equal to address[19:1].
- mem_wdata  out  16  backend write data; the byte is replicated in both halves.
- mem_be  out  2  byte enables; [0] selects the even byte, [1] the odd byte.
- mem_we  out  1  backend write qualifier, valid while mem_req=1.
- mem_req  out  1  backend request.
- mem_rdata  in  16  backend read data, valid in the mem_ack cycle.
- mem_ack  in  1  single-cycle completion pulse.

Behaviour:
- Reset: locked=0, mem_req=0, mem_we=0, mem_be=0, line_valid=0, state=IDLE. All outputs remain at these values while reset=1.
- Reset asserted mid-transaction: mem_req drops the next cycle. The fill or write is abandoned, and a late mem_ack is ignored.
- Line buffer: line_tag[18:0], line_data[15:0], line_valid.
  - hit = line_valid && line_tag==address[19:1].
  - in = address[0] ? line_data[15:8] : line_data[7:0], selected combinationally.
- FSM has four states: IDLE, RD_REQ, WR_REQ, WR_DONE.
- IDLE:
  - we=0 and hit: locked=1 combinationally, so reads take zero wait states.
  - we=0 and miss: locked=0; next state RD_REQ.
  - we=1: locked=0; next state WR_REQ; the write address and data are latched.
- RD_REQ:
  - mem_req=1, mem_we=0, mem_be=2'b11, locked=0.
  - On mem_ack: line_data<=mem_rdata, line_tag<=address[19:1], line_valid<=1; go to IDLE, which then hits.
  - Read miss latency is 2 cycles plus backend latency.
- WR_REQ:
  - mem_req=1, mem_we=1, mem_be={addr[0],~addr[0]}, locked=0.
  - On mem_ack: if the latched tag equals line_tag, update the matching byte of line_data (write-through, no allocate); go to WR_DONE.
- WR_DONE:
  - locked=1 for exactly one cycle, so the CPU commits that write; then go to IDLE.
  - If we is still 1 in the following IDLE cycle (e.g. the core's write-end cycle), it is treated as a new write. Rewriting the same byte is harmless.
- Handshake rules:
  - mem_req rises from IDLE and stays high with stable mem_addr/mem_wdata/mem_be/mem_we until the mem_ack cycle, inclusive.
  - mem_req is low the cycle after mem_ack.
  - mem_ack while mem_req=0 is ignored.
- Address change during a wait is impossible: the core holds address while locked=0. The bench still checks that mem_addr stays stable.
- Wrap-around: address 20'hFFFFF lies in word 19'h7FFFF and is odd. There is no carry into other words, because all accesses are byte-granular.

Optional Feature:
- Macro: MEM_BRIDGE16_ROM_PROTECT_EN.
- Defined: writes with address >= ROM_BASE never raise mem_req. IDLE goes straight to WR_DONE, so the write is acknowledged with one wait cycle and memory and line buffer are unchanged. Reads in the region are unaffected.
- Undefined: all writes go to the backend; ROM_BASE is unused.

Decomposition:
- Package mem_bridge16_pkg:
  - state enum {IDLE, RD_REQ, WR_REQ, WR_DONE};
  - ROM_BASE default constant;
  - byte-enable helper constants BE_LO=2'b01, BE_HI=2'b10, BE_W=2'b11.
- One sub-module, mem_bridge16_line: holds tag, valid and data. It provides the hit compare, byte select, fill port and byte-update port. The FSM and handshake stay in the top module.

Test Plan:
- Cold read: after reset, address=20'h00100 with backend data 16'hBEEF and ack after 3 cycles.
  - locked=0 until the fill completes, then locked=1 with in=8'hEF.
  - The next address 20'h00101 hits in zero waits with in=8'hBE.
- Write-through hit: line holds word 19'h00080=16'hBEEF; write 8'h55 to 20'h00101.
  - mem_be=2'b10, mem_wdata=16'h5555, mem_we=1.
  - After ack, locked=1 for 1 cycle; reading 20'h00101 returns 8'h55 without a backend request.
- Write miss: write 8'hAA to 20'h02000 with the line holding another tag.
  - The line is unchanged; a following read of 20'h02000 misses and fills.
- Reset mid-read: assert reset while mem_req=1.
  - The next cycle shows mem_req=0, locked=0, line_valid=0.
  - A stale mem_ack 2 cycles later causes no state change.
- Backend stall: hold mem_ack=0 for 20 cycles.
  - mem_req, mem_addr and mem_be stay stable and locked=0 throughout.
  - Ack in cycle 21 completes normally.
- ROM protect (macro defined): write 8'h12 to 20'hFFFF0.
  - mem_req is never asserted; locked=1 on the second cycle.
  - Readback returns the original backend value.

Source files
------------

// File: rtl/mem_bridge16_pkg.sv
// Shared types and constants for the 8-bit CPU bus to 16-bit word memory bridge.
// No logic; latency and backpressure live in mem_bridge16.
package mem_bridge16_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    WR_REQ  = 2'd2,
    WR_DONE = 2'd3
  } state_t;

  localparam logic [19:0] ROM_BASE_DEF = 20'hF0000;

  localparam logic [1:0] BE_LO = 2'b01;
  localparam logic [1:0] BE_HI = 2'b10;
  localparam logic [1:0] BE_W  = 2'b11;

endpackage

// File: rtl/mem_bridge16_if.sv
// CPU byte bus (address/out/we/in/locked) plus backend word req/ack bus.
// master = CPU and memory side, slave = the bridge.
interface mem_bridge16_if #(
  parameter int ADDR_W = 20
);
  logic [ADDR_W-1:0] address;
  logic [7:0]        out;
  logic              we;
  logic [7:0]        in;
  logic              locked;

  logic [ADDR_W-2:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [1:0]        mem_be;
  logic              mem_we;
  logic              mem_req;
  logic [15:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output address, out, we, mem_rdata, mem_ack,
    input  in, locked, mem_addr, mem_wdata, mem_be, mem_we, mem_req
  );

  modport slave (
    input  address, out, we, mem_rdata, mem_ack,
    output in, locked, mem_addr, mem_wdata, mem_be, mem_we, mem_req
  );
endinterface

// File: rtl/mem_bridge16_line.sv
// One-word read line buffer: combinational hit/byte select, registered fill and byte update.
// Zero-cycle lookup; fill and update land on the next clock edge, no backpressure.
module mem_bridge16_line #(
  parameter int TAG_W = 19
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [TAG_W-1:0] lookup_tag,
  input  logic             byte_sel,
  output logic             hit,
  output logic [7:0]       rd_byte,
  input  logic             fill_en,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [15:0]      fill_data,
  input  logic             upd_en,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic             upd_hi,
  input  logic [7:0]       upd_byte
);

  logic [TAG_W-1:0] line_tag;
  logic [15:0]      line_data;
  logic             line_valid;

  assign hit     = line_valid && (line_tag == lookup_tag);
  assign rd_byte = byte_sel ? line_data[15:8] : line_data[7:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      line_valid <= 1'b0;
      line_tag   <= '0;
      line_data  <= '0;
    end else if (fill_en) begin
      line_valid <= 1'b1;
      line_tag   <= fill_tag;
      line_data  <= fill_data;
    end else if (upd_en && line_valid && (line_tag == upd_tag)) begin
      // write-through: only a resident word is patched, misses never allocate
      if (upd_hi) begin
        line_data[15:8] <= upd_byte;
      end else begin
        line_data[7:0]  <= upd_byte;
      end
    end
  end

endmodule

// File: rtl/mem_bridge16.sv
// Bridges CPU byte accesses onto a 16-bit req/ack word memory; MEM_BRIDGE16_ROM_PROTECT_EN drops writes at/above ROM_BASE.
// Line hits read in 0 waits, misses take 2+backend cycles; locked=0 stalls the CPU until the backend acks.
module mem_bridge16
  import mem_bridge16_pkg::*;
#(
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] ROM_BASE = ROM_BASE_DEF
) (
  input logic           clock,
  input logic           reset,
  mem_bridge16_if.slave bus
);

  localparam int TAG_W = ADDR_W - 1;

`ifdef MEM_BRIDGE16_ROM_PROTECT_EN
  localparam bit ROM_PROTECT = 1'b1;
`else
  localparam bit ROM_PROTECT = 1'b0;
`endif

  state_t           state;
  logic [TAG_W-1:0] mem_addr_q;
  logic [15:0]      mem_wdata_q;
  logic [1:0]       mem_be_q;
  logic             mem_we_q;
  logic             mem_req_q;

  logic             hit;
  logic [7:0]       line_byte;
  logic             rom_hit;
  logic             fill_en;
  logic             upd_en;

  assign rom_hit = ROM_PROTECT && (bus.address >= ROM_BASE);
  assign fill_en = (state == RD_REQ) && mem_req_q && bus.mem_ack;
  assign upd_en  = (state == WR_REQ) && mem_req_q && bus.mem_ack;

  mem_bridge16_line #(
    .TAG_W (TAG_W)
  ) u_line (
    .clock      (clock),
    .reset      (reset),
    .lookup_tag (bus.address[ADDR_W-1:1]),
    .byte_sel   (bus.address[0]),
    .hit        (hit),
    .rd_byte    (line_byte),
    .fill_en    (fill_en),
    .fill_tag   (mem_addr_q),
    .fill_data  (bus.mem_rdata),
    .upd_en     (upd_en),
    .upd_tag    (mem_addr_q),
    .upd_hi     (mem_be_q[1]),
    .upd_byte   (mem_wdata_q[7:0])
  );

  // hit path is combinational so line reads cost no wait state
  assign bus.locked    = !reset && (((state == IDLE) && !bus.we && hit) || (state == WR_DONE));
  assign bus.in        = line_byte;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_req   = mem_req_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_req_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.we) begin
            mem_addr_q  <= bus.address[ADDR_W-1:1];
            mem_wdata_q <= {bus.out, bus.out};
            if (rom_hit) begin
              state <= WR_DONE;
            end else begin
              state     <= WR_REQ;
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b1;
              mem_be_q  <= bus.address[0] ? BE_HI : BE_LO;
            end
          end else if (!hit) begin
            state      <= RD_REQ;
            mem_addr_q <= bus.address[ADDR_W-1:1];
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_be_q   <= BE_W;
          end
        end
        RD_REQ: begin
          if (bus.mem_ack) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
            mem_be_q  <= '0;
          end
        end
        WR_REQ: begin
          if (bus.mem_ack) begin
            state     <= WR_DONE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_be_q  <= '0;
          end
        end
        WR_DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge16.sv
// Table-driven bench for mem_bridge16 with a backend memory model and a read scoreboard queue.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_mem_bridge16;

  logic clock;
  logic reset;

  mem_bridge16_if #(.ADDR_W(20)) bus ();

  mem_bridge16 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int last_reqc = 0;

  logic [7:0]  sb_q [$];
  logic [15:0] bmem [logic [18:0]];

  typedef struct {
    logic [19:0] addr;
    logic        wr;
    logic [7:0]  wd;
    int          dly;
    int          waits;
    logic [7:0]  rd;
    logic [1:0]  be;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] bread(input logic [18:0] w);
    if (bmem.exists(w)) return bmem[w];
    return 16'h0000;
  endfunction

  // One CPU access; the backend acks in the dly-th cycle that mem_req is seen high.
  task automatic cpu_access(input string nm, input logic [19:0] a, input logic wr,
                            input logic [7:0] wd, input int dly, input int exp_waits,
                            input logic [7:0] exp_rd, input logic [1:0] exp_be);
    int          waits;
    int          reqc;
    bit          done;
    logic [15:0] word;
    waits = 0;
    reqc  = 0;
    done  = 1'b0;
    bus.address = a;
    bus.we      = wr;
    bus.out     = wd;
    if (!wr) sb_q.push_back(exp_rd);
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      bus.mem_ack = 1'b0;
      if (bus.locked) begin
        done = 1'b1;
        chk({nm, "_req_low"}, 32'(bus.mem_req), 32'd0);
        if (!wr) chk({nm, "_rd"}, 32'(bus.in), 32'(sb_q.pop_front()));
      end else begin
        waits++;
        if (bus.mem_req) begin
          reqc++;
          chk({nm, "_maddr"}, 32'(bus.mem_addr), 32'(a[19:1]));
          chk({nm, "_mbe"}, 32'(bus.mem_be), 32'(exp_be));
          chk({nm, "_mwe"}, 32'(bus.mem_we), 32'(wr));
          if (wr) chk({nm, "_mwdata"}, 32'(bus.mem_wdata), 32'({wd, wd}));
          if (reqc == dly) begin
            bus.mem_ack = 1'b1;
            word = bread(bus.mem_addr);
            bus.mem_rdata = word;
            if (bus.mem_we) begin
              if (bus.mem_be[0]) word[7:0]  = bus.mem_wdata[7:0];
              if (bus.mem_be[1]) word[15:8] = bus.mem_wdata[15:8];
              bmem[bus.mem_addr] = word;
            end
          end
        end
      end
      @(negedge clock);
    end
    last_reqc = reqc;
    chk({nm, "_done"}, 32'(done), 32'd1);
    if (!done && !wr && sb_q.size() > 0) void'(sb_q.pop_back());
    chk({nm, "_waits"}, 32'(waits), 32'(exp_waits));
  endtask

  initial begin
    tbl[0]  = '{20'h00100, 1'b0, 8'h00,  3,  4, 8'hEF, 2'b11};
    tbl[1]  = '{20'h00101, 1'b0, 8'h00,  0,  0, 8'hBE, 2'b11};
    tbl[2]  = '{20'h00100, 1'b0, 8'h00,  0,  0, 8'hEF, 2'b11};
    tbl[3]  = '{20'h00101, 1'b1, 8'h55,  2,  3, 8'h00, 2'b10};
    tbl[4]  = '{20'h00101, 1'b0, 8'h00,  0,  0, 8'h55, 2'b11};
    tbl[5]  = '{20'h00100, 1'b0, 8'h00,  0,  0, 8'hEF, 2'b11};
    tbl[6]  = '{20'h02000, 1'b1, 8'hAA,  1,  2, 8'h00, 2'b01};
    tbl[7]  = '{20'h00101, 1'b0, 8'h00,  0,  0, 8'h55, 2'b11};
    tbl[8]  = '{20'h02000, 1'b0, 8'h00,  2,  3, 8'hAA, 2'b11};
    tbl[9]  = '{20'h02001, 1'b0, 8'h00,  0,  0, 8'h12, 2'b11};
    tbl[10] = '{20'hFFFFF, 1'b0, 8'h00,  1,  2, 8'hC3, 2'b11};
    tbl[11] = '{20'hFFFFE, 1'b0, 8'h00,  0,  0, 8'hA5, 2'b11};
    tbl[12] = '{20'h00100, 1'b0, 8'h00,  1,  2, 8'hEF, 2'b11};
    tbl[13] = '{20'h00100, 1'b1, 8'h11,  1,  2, 8'h00, 2'b01};
    tbl[14] = '{20'h00100, 1'b1, 8'h22,  1,  2, 8'h00, 2'b01};
    tbl[15] = '{20'h00100, 1'b0, 8'h00,  0,  0, 8'h22, 2'b11};
    tbl[16] = '{20'h00101, 1'b0, 8'h00,  0,  0, 8'h55, 2'b11};
    tbl[17] = '{20'h06000, 1'b0, 8'h00, 21, 22, 8'h3C, 2'b11};

    bmem[19'h00080] = 16'hBEEF;
    bmem[19'h01000] = 16'h1234;
    bmem[19'h03000] = 16'h4B3C;
    bmem[19'h7FFF8] = 16'h6789;
    bmem[19'h7FFFF] = 16'hC3A5;

    reset         = 1'b1;
    bus.address   = 20'h00100;
    bus.we        = 1'b1;
    bus.out       = 8'h00;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;

    // reset state, with a write strobe held to show it is ignored
    repeat (3) @(negedge clock);
    #1;
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_req",    32'(bus.mem_req), 32'd0);
    chk("rst_we",     32'(bus.mem_we), 32'd0);
    chk("rst_be",     32'(bus.mem_be), 32'd0);
    bus.we = 1'b0;
    reset  = 1'b0;

    for (int i = 0; i < 18; i++) begin
      cpu_access($sformatf("vec%0d", i), tbl[i].addr, tbl[i].wr, tbl[i].wd,
                 tbl[i].dly, tbl[i].waits, tbl[i].rd, tbl[i].be);
    end

    // reset while a fill is outstanding, then a stale ack
    bus.address = 20'h04000;
    bus.we      = 1'b0;
    #1;
    chk("rmr_miss_locked", 32'(bus.locked), 32'd0);
    @(negedge clock);
    #1;
    chk("rmr_req_up", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    #1;
    chk("rmr_req_drop",  32'(bus.mem_req), 32'd0);
    chk("rmr_locked",    32'(bus.locked), 32'd0);
    chk("rmr_be_clear",  32'(bus.mem_be), 32'd0);
    @(negedge clock);
    #1;
    reset         = 1'b0;
    bus.address   = 20'h06000;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    #1;
    chk("rmr_line_inv",  32'(bus.locked), 32'd0);
    chk("rmr_stale_req", 32'(bus.mem_req), 32'd0);
    @(negedge clock);
    bus.mem_ack = 1'b0;
    cpu_access("rmr_refill", 20'h06000, 1'b0, 8'h00, 1, 1, 8'h3C, 2'b11);

    // write into the protected region, then read it back
`ifdef MEM_BRIDGE16_ROM_PROTECT_EN
    cpu_access("rom_wr", 20'hFFFF0, 1'b1, 8'h12, 1, 1, 8'h00, 2'b01);
    chk("rom_no_req", 32'(last_reqc), 32'd0);
    cpu_access("rom_rd", 20'hFFFF0, 1'b0, 8'h00, 1, 2, 8'h89, 2'b11);
`else
    cpu_access("rom_wr", 20'hFFFF0, 1'b1, 8'h12, 1, 2, 8'h00, 2'b01);
    chk("rom_req", 32'(last_reqc), 32'd1);
    cpu_access("rom_rd", 20'hFFFF0, 1'b0, 8'h00, 1, 2, 8'h12, 2'b11);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
